// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable/divider bank.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 24;
    // Clamp arithmetic runs at this width; channel widths must stay below it.
    localparam int unsigned CNT_W_MAX = 32;
    localparam int unsigned DIV_MIN   = 2;

    typedef logic [CNT_W_MAX-1:0] cval_t;

    typedef struct packed {
        cval_t div;
        cval_t high;
    } cfg_t;

    // Force a request into a legal shape: divisor of at least DIV_MIN and a
    // high time strictly inside the period, so every channel always toggles.
    function automatic cfg_t clamp_cfg(input cval_t div, input cval_t high);
        cfg_t r;
        r.div  = (div < cval_t'(DIV_MIN)) ? cval_t'(DIV_MIN) : div;
        r.high = (high == '0) ? cval_t'(1) : high;
        if (r.high > r.div - cval_t'(1)) begin
            r.high = r.div - cval_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow config, pending bit, registered outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DIV_INIT = 10
) (
    input  logic             clk_ref_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    output logic             pending_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] high_q,  high_d;
    logic [CNT_W-1:0] sdiv_q,  sdiv_d;
    logic [CNT_W-1:0] shigh_q, shigh_d;
    logic             pend_q,  pend_d;
    logic             clk_q,   clk_d;
    logic             tick_q,  tick_d;

    logic             wrap;
    logic             load;
    logic [CNT_W-1:0] high_use;
    cfg_t             req;
    logic             unused_req_hi;

    assign req = clamp_cfg(cval_t'(cfg_div_i), cval_t'(cfg_high_i));
    // Clamped results never exceed the request width, so the upper bits are always zero.
    assign unused_req_hi = (|(req.div >> CNT_W)) | (|(req.high >> CNT_W));

    // Next-state: shadow apply at period boundary (wrap/sync) or while idle, then counter/outputs.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        high_d   = high_q;
        sdiv_d   = sdiv_q;
        shigh_d  = shigh_q;
        pend_d   = pend_q;
        clk_d    = clk_q;
        tick_d   = tick_q;

        wrap     = (cnt_q == div_q - CNT_W'(1));
        load     = pend_q && (!en_i || sync_i || wrap);
        high_use = high_q;

        if (load) begin
            div_d    = sdiv_q;
            high_d   = shigh_q;
            high_use = shigh_q;
            pend_d   = 1'b0;
        end

        // Accept is only possible with pend_q clear, so it never collides with a load;
        // an accept on a boundary cycle therefore waits for the following boundary.
        if (wr_i) begin
            sdiv_d  = req.div[CNT_W-1:0];
            shigh_d = req.high[CNT_W-1:0];
            pend_d  = 1'b1;
        end

        if (!en_i) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
        end else if (sync_i) begin
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b1;
        end else begin
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
            clk_d  = (cnt_d < high_use);
            tick_d = wrap;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_ref_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            div_q   <= CNT_W'(DIV_INIT);
            high_q  <= CNT_W'(DIV_INIT / 2);
            sdiv_q  <= CNT_W'(DIV_INIT);
            shigh_q <= CNT_W'(DIV_INIT / 2);
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            sdiv_q  <= sdiv_d;
            shigh_q <= shigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable/divider bank: cfg demux, ready mux, channel array.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int unsigned N_CH     = 4,
    parameter  int unsigned CNT_W    = CNT_W_DEF,
    parameter  int unsigned DIV_INIT = 10,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] wr;

    assign cfg_ready = ~pend[cfg_ch];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk_ref_i  (clk_ref),
            .rst_i      (rst),
            .en_i       (en[i]),
            .sync_i     (sync),
            .wr_i       (wr[i]),
            .cfg_div_i  (cfg_div),
            .cfg_high_i (cfg_high),
            .pending_o  (pend[i]),
            .clk_out_o  (clk_out[i]),
            .tick_o     (tick[i])
        );
    end

endmodule
